// File: rtl/dz_counter.sv
// -----------------------------------------------------------------------------
// dz_counter -- one-digit up/down sequencer feeding the dot-matrix display.
//
// Counts 0 -> MAX_NUM (dir=0) or MAX_NUM -> 0 (dir=1), one step every TICK_DIV
// clk cycles (1 s at the 1 kHz system clock). A start button toggles
// run/pause, restarts from DONE, or launches from IDLE. A clear button returns
// to IDLE from any state. A one-cycle `done` pulse marks the terminal value.
//
// Optional build macro: DZ_BTN_DEBOUNCE_EN
//   defined   : each synchronised button is debounced over DB_CYCLES cycles
//               before edge detection.
//   undefined : edge detection runs directly on the synchronised level.
//
// Parameters
//   TICK_DIV  clk cycles per count step (>= 1)
//   MAX_NUM   terminal/start value (1..7)
//   DB_CYCLES debounce stability window in clk cycles (>= 1)
//
// Ports
//   clk        in   system clock, 1 kHz
//   rst        in   synchronous reset, active-high
//   btn_start  in   raw start/pause button level, active-high
//   btn_clr    in   raw clear button level, active-high
//   dir        in   0 = count up, 1 = count down; sampled only in IDLE
//   num  [2:0] out  current digit for the display stage
//   running    out  high while in RUN
//   done       out  one-cycle pulse when the terminal value is reached
// -----------------------------------------------------------------------------
module dz_counter #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned MAX_NUM   = 5,
  parameter int unsigned DB_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clr,
  input  logic       dir,
  output logic [2:0] num,
  output logic       running,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [2:0]    MAX_V      = 3'(MAX_NUM);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if (MAX_NUM < 1 || MAX_NUM > 7 || TICK_DIV < 1 || DB_CYCLES < 1) begin : g_param_check
    $error("dz_counter: MAX_NUM must be 1..7, TICK_DIV and DB_CYCLES >= 1");
  end

  // ---------------------------------------------------------------------------
  // Button path. Bit 0 = start, bit 1 = clear.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] sync_ok_q;   // sync_ok_q[1]: sync2_q now holds a real sample
  logic [1:0] arm_q;       // button has been seen released since reset
  logic [1:0] lvl;         // level fed to the edge detector
  logic [1:0] lvl_prev_q;
  logic [1:0] press_q;     // one-cycle press pulses

  assign btn_raw = {btn_clr, btn_start};

  // The synchroniser resets to 0, so a button held through reset would look
  // like a fresh rise once it emerges. Presses are only accepted after the
  // button has genuinely been sampled low, which suppresses that false edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its sources; blocking here would collapse the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync_ok_q  <= '0;
      arm_q      <= '0;
      lvl_prev_q <= '0;
      press_q    <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      sync_ok_q  <= {sync_ok_q[0], 1'b1};
      arm_q      <= arm_q | ({2{sync_ok_q[1]}} & ~sync2_q);
      lvl_prev_q <= lvl;
      press_q    <= lvl & ~lvl_prev_q & arm_q;
    end
  end

`ifdef DZ_BTN_DEBOUNCE_EN
  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]         db_q;
  logic [1:0][CW-1:0] db_cnt_q;

  // The debounced level follows the synchronised input only after it has
  // disagreed for DB_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] != db_q[b]) begin
          if (db_cnt_q[b] == DB_LAST) begin
            db_q[b]     <= sync2_q[b];
            db_cnt_q[b] <= '0;
          end else begin
            db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
          end
        end else begin
          db_cnt_q[b] <= '0;
        end
      end
    end
  end

  assign lvl = db_q;
`else
  assign lvl = sync2_q;
`endif

  logic start_press;
  logic clr_press;
  assign start_press = press_q[0];
  assign clr_press   = press_q[1];

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [2:0]    num_q, num_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic [2:0] idle_num;
  logic [2:0] step_num;
  logic [2:0] term_num;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    presc_d  = presc_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    idle_num = dir ? MAX_V : 3'd0;
    step_num = dir_q ? (num_q - 3'd1) : (num_q + 3'd1);
    term_num = dir_q ? 3'd0 : MAX_V;

    if (clr_press) begin
      // Clear outranks a coincident start press.
      state_d = S_IDLE;
      dir_d   = dir;
      num_d   = idle_num;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dir_d   = dir;
          num_d   = idle_num;
          presc_d = '0;
          if (start_press) state_d = S_RUN;
        end
        S_RUN: begin
          if (start_press) begin
            // Pause wins over a coincident step; prescaler keeps its phase.
            state_d = S_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            num_d   = step_num;
            if (step_num == term_num) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (start_press) state_d = S_RUN;
        end
        S_DONE: begin
          if (start_press) begin
            num_d   = dir_q ? MAX_V : 3'd0;
            presc_d = '0;
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_q     <= 3'd0;
      presc_q   <= '0;
      dir_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign num     = num_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dz_counter.sv
// -----------------------------------------------------------------------------
// tb_dz_counter -- scoreboard bench for dz_counter (TICK_DIV=4, MAX_NUM=5,
// DB_CYCLES=20). Stimulus pushes {cycle, num, running, done} expectations into
// a time-ordered queue; a negedge monitor pops and compares each entry when
// its cycle comes up. Built with DZ_BTN_DEBOUNCE_EN it runs the debounce
// scenarios instead of the undebounced ones.
// -----------------------------------------------------------------------------
module tb_dz_counter;

  localparam int TICK_DIV  = 4;
  localparam int MAX_NUM   = 5;
  localparam int DB_CYCLES = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_clr = 1'b0;
  logic       dir = 1'b1;
  logic [2:0] num;
  logic       running;
  logic       done;

  dz_counter #(
    .TICK_DIV (TICK_DIV),
    .MAX_NUM  (MAX_NUM),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_clr  (btn_clr),
    .dir      (dir),
    .num      (num),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [2:0] num;
    logic       run;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s @cycle %0d: got num=%0d running=%0b done=%0b, want num=%0d running=%0b done=%0b",
               tag, cyc, got[4:2], got[1], got[0], want[4:2], want[1], want[0]);
    else
      n_pass++;
  endtask

  // Sorted insert keeps the queue ordered by cycle.
  function automatic void expect_at(input int at, input int n, input logic r,
                                    input logic d, input string tag);
    exp_t e;
    int   i;
    e.at   = at;
    e.num  = 3'(n);
    e.run  = r;
    e.done = d;
    e.tag  = tag;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endfunction

  function automatic void expect_span(input int from, input int to, input int n,
                                      input logic r, input logic d, input string tag);
    for (int c = from; c <= to; c++) expect_at(c, n, r, d, tag);
  endfunction

  // Monitor: compares outputs half a cycle after each edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at != cyc) begin
        n_checks++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.tag, e.at, cyc);
      end else begin
        check(e.tag, {num, running, done}, {e.num, e.run, e.done});
      end
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    btn_start = 1'b1;
    adv(1);
    btn_start = 1'b0;
  endtask

  initial begin : stim
    int t, u, w, x;

    // Reset for two edges, then IDLE with dir=1 loads MAX_NUM.
    expect_span(1, 2, 0, 1'b0, 1'b0, "reset");
    adv(2);
    rst = 1'b0;
    expect_span(3, 5, MAX_NUM, 1'b0, 1'b0, "idle_down");
    adv(3);

`ifdef DZ_BTN_DEBOUNCE_EN
    // 10-cycle glitch is rejected.
    t = cyc;
    expect_span(t + 1, t + 50, MAX_NUM, 1'b0, 1'b0, "glitch_reject");
    btn_start = 1'b1;
    adv(10);
    btn_start = 1'b0;
    adv(40);

    // 25-cycle press: RUN 24 cycles after driving (4 + DB_CYCLES).
    t = cyc;
    expect_span(t + 1, t + 23, MAX_NUM, 1'b0, 1'b0, "db_wait");
    expect_span(t + 24, t + 27, MAX_NUM, 1'b1, 1'b0, "db_run");
    expect_at(t + 28, 4, 1'b1, 1'b0, "db_step");
    btn_start = 1'b1;
    adv(25);
    btn_start = 1'b0;
    adv(10);
`else
    // Count down 5..0, done coincident with 0, running falls together.
    t = cyc;
    expect_span(t + 1, t + 3, 5, 1'b0, 1'b0, "dn_idle");
    expect_span(t + 4,  t + 7,  5, 1'b1, 1'b0, "dn_5");
    expect_span(t + 8,  t + 11, 4, 1'b1, 1'b0, "dn_4");
    expect_span(t + 12, t + 15, 3, 1'b1, 1'b0, "dn_3");
    expect_span(t + 16, t + 19, 2, 1'b1, 1'b0, "dn_2");
    expect_span(t + 20, t + 23, 1, 1'b1, 1'b0, "dn_1");
    expect_at(t + 24, 0, 1'b0, 1'b1, "dn_done");
    expect_span(t + 25, t + 26, 0, 1'b0, 1'b0, "dn_hold");
    pulse_start();
    adv(25);

    // Clear out of DONE with dir=0.
    t = cyc;
    expect_span(t + 1, t + 6, 0, 1'b0, 1'b0, "clr_done");
    dir = 1'b0;
    btn_clr = 1'b1;
    adv(1);
    btn_clr = 1'b0;
    adv(5);

    // Count up 0..5.
    t = cyc;
    expect_span(t + 1, t + 3, 0, 1'b0, 1'b0, "up_idle");
    expect_span(t + 4,  t + 7,  0, 1'b1, 1'b0, "up_0");
    expect_span(t + 8,  t + 11, 1, 1'b1, 1'b0, "up_1");
    expect_span(t + 12, t + 15, 2, 1'b1, 1'b0, "up_2");
    expect_span(t + 16, t + 19, 3, 1'b1, 1'b0, "up_3");
    expect_span(t + 20, t + 23, 4, 1'b1, 1'b0, "up_4");
    expect_at(t + 24, 5, 1'b0, 1'b1, "up_done");
    expect_span(t + 25, t + 27, 5, 1'b0, 1'b0, "up_hold");
    pulse_start();
    adv(26);

    // Start in DONE reloads 0; dir change mid-run ignored; clr in RUN.
    t = cyc;
    expect_span(t + 1, t + 3, 5, 1'b0, 1'b0, "restart_wait");
    expect_span(t + 4, t + 7, 0, 1'b1, 1'b0, "restart_0");
    expect_span(t + 8, t + 11, 1, 1'b1, 1'b0, "restart_1");
    expect_at(t + 12, 2, 1'b1, 1'b0, "dir_ignored");
    expect_span(t + 13, t + 16, 5, 1'b0, 1'b0, "clr_run");
    pulse_start();
    adv(8);
    dir = 1'b1;
    btn_clr = 1'b1;
    adv(1);
    btn_clr = 1'b0;
    adv(6);

    // Pause two cycles past a step, hold 20 cycles, resume keeps phase,
    // then simultaneous start+clr at num=3 returns to IDLE.
    u = cyc;
    expect_span(u + 1,  u + 3,  5, 1'b0, 1'b0, "pz_idle");
    expect_span(u + 4,  u + 7,  5, 1'b1, 1'b0, "pz_5");
    expect_span(u + 8,  u + 10, 4, 1'b1, 1'b0, "pz_4");
    expect_span(u + 11, u + 30, 4, 1'b0, 1'b0, "pz_hold");
    expect_span(u + 31, u + 32, 4, 1'b1, 1'b0, "pz_resume");
    expect_span(u + 33, u + 34, 3, 1'b1, 1'b0, "pz_phase");
    expect_span(u + 35, u + 45, 5, 1'b0, 1'b0, "start_clr");
    pulse_start();
    adv(6);
    pulse_start();
    adv(19);
    pulse_start();
    adv(3);
    btn_start = 1'b1;
    btn_clr   = 1'b1;
    adv(1);
    btn_start = 1'b0;
    btn_clr   = 1'b0;
    adv(13);

    // rst mid-count with btn_start held: no retrigger after release.
    w = cyc;
    expect_span(w + 1,  w + 3,  5, 1'b0, 1'b0, "rr_idle");
    expect_span(w + 4,  w + 7,  5, 1'b1, 1'b0, "rr_5");
    expect_span(w + 8,  w + 11, 4, 1'b1, 1'b0, "rr_4");
    expect_span(w + 12, w + 15, 3, 1'b1, 1'b0, "rr_3");
    expect_span(w + 16, w + 17, 2, 1'b1, 1'b0, "rr_2");
    expect_at(w + 18, 0, 1'b0, 1'b0, "rr_reset");
    expect_span(w + 19, w + 40, 5, 1'b0, 1'b0, "rr_no_retrig");
    pulse_start();
    adv(16);
    rst       = 1'b1;
    btn_start = 1'b1;
    adv(1);
    rst = 1'b0;
    adv(22);

    // Release, then a fresh press starts normally.
    x = cyc;
    expect_span(x + 1, x + 8, 5, 1'b0, 1'b0, "rel_idle");
    expect_at(x + 9, 5, 1'b1, 1'b0, "rel_press");
    btn_start = 1'b0;
    adv(5);
    pulse_start();
    adv(4);
`endif

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 200 && sb.size() > 0; i++) adv(1);
    while (sb.size() > 0) begin
      n_checks++;
      $display("FAIL %s: expectation for cycle %0d never checked", sb[0].tag, sb[0].at);
      void'(sb.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
